// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//
// Direct-mapped, read-only instruction cache sitting between the IF stage and
// instruction memory. Each line holds 8 words (32 bytes). Hits are answered
// combinationally in the same cycle, returning the addressed word and the
// word after it for dual-issue fetch. A miss starts a single block fill over
// the IM block interface; IF stalls while Instr_valid_2IF is low.
//
// Ports
//   CLK                  : single clock, all state updates on the rising edge
//   RESET                : synchronous active-high reset
//   Instr_address_fIF    : byte fetch address from IF (bits [1:0] ignored)
//   Flush                : invalidate every line, abort any fill in progress
//   Instr1_2IF           : word at the fetch address (0 when not valid)
//   Instr2_2IF           : word at fetch address + 4 (0 when not valid)
//   Instr_valid_2IF      : Instr1_2IF is valid (hit in IDLE, no Flush)
//   Instr2_valid_2IF     : Instr2_2IF is valid (hit and word index < 7)
//   Instr_address_2IM    : line-aligned block address to instruction memory
//   iBlkRead             : block read request, held for the whole fill
//   block_read_fIM       : returned line, word w at bits [32w+31:32w]
//   block_read_fIM_valid : returned line is valid this cycle
//   Miss_count           : fills started since reset, wraps at 2^32
// ---------------------------------------------------------------------------
module icache_direct #(
    parameter int INDEX_BITS = 5
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  Instr_address_fIF,
    input  logic         Flush,
    output logic [31:0]  Instr1_2IF,
    output logic [31:0]  Instr2_2IF,
    output logic         Instr_valid_2IF,
    output logic         Instr2_valid_2IF,
    output logic [31:0]  Instr_address_2IM,
    output logic         iBlkRead,
    input  logic [255:0] block_read_fIM,
    input  logic         block_read_fIM_valid,
    output logic [31:0]  Miss_count
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } CacheState;

    // Control state
    CacheState           stateQ, stateD;
    logic [26:0]         lineAddrQ, lineAddrD;
    logic [31:0]         missCountQ, missCountD;
    logic [LINES-1:0]    validQ, validD;

    // Line storage (not reset; the valid bits guard it)
    logic [TAG_BITS-1:0] tagQ  [LINES];
    logic [31:0]         dataQ [LINES][8];

    // Fetch address fields
    logic [2:0]            fetchWord;
    logic [2:0]            nextWord;
    logic [INDEX_BITS-1:0] fetchIndex;
    logic [TAG_BITS-1:0]   fetchTag;

    // Latched fill line fields
    logic [INDEX_BITS-1:0] fillIndex;
    logic [TAG_BITS-1:0]   fillTag;

    logic        tagMatch;
    logic        hit;
    logic        hit2;
    logic        fillWe;
    logic        blkReadReq;
    logic [31:0] imAddr;

    // The byte offset within a word is never needed by the cache.
    logic        unusedAddrBits;
    assign unusedAddrBits = ^Instr_address_fIF[1:0];

    // Split the fetch address into word / index / tag, and the latched
    // line address into the index and tag the fill will write.
    always_comb begin
        fetchWord  = Instr_address_fIF[4:2];
        nextWord   = fetchWord + 3'd1;
        fetchIndex = Instr_address_fIF[4+INDEX_BITS:5];
        fetchTag   = Instr_address_fIF[31:5+INDEX_BITS];
        fillIndex  = lineAddrQ[INDEX_BITS-1:0];
        fillTag    = lineAddrQ[26:INDEX_BITS];
        tagMatch   = validQ[fetchIndex] && (tagQ[fetchIndex] == fetchTag);
    end

    // Next-state logic. In IDLE a lookup either hits or starts a fill for
    // the fetched line. In FILL the fetch address is ignored and the
    // request is held until memory answers. Flush wins over everything:
    // it wipes the valid bits and drops any fill without writing it.
    always_comb begin
        stateD     = stateQ;
        lineAddrD  = lineAddrQ;
        missCountD = missCountQ;
        validD     = validQ;
        fillWe     = 1'b0;
        hit        = 1'b0;
        blkReadReq = 1'b0;
        imAddr     = {Instr_address_fIF[31:5], 5'b0};

        case (stateQ)
            IDLE: begin
                if (Flush) begin
                    validD = '0;
                end else if (tagMatch) begin
                    hit = 1'b1;
                end else begin
                    lineAddrD  = Instr_address_fIF[31:5];
                    missCountD = missCountQ + 32'd1;
                    stateD     = FILL;
                end
            end
            FILL: begin
                blkReadReq = 1'b1;
                imAddr     = {lineAddrQ, 5'b0};
                if (Flush) begin
                    validD = '0;
                    stateD = IDLE;
                end else if (block_read_fIM_valid) begin
                    fillWe            = 1'b1;
                    validD[fillIndex] = 1'b1;
                    stateD            = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Control registers, cleared by reset. Reset mid-fill simply returns
    // to IDLE with every line invalid, abandoning the fill.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stateQ     <= IDLE;
            lineAddrQ  <= '0;
            missCountQ <= '0;
            validQ     <= '0;
        end else begin
            stateQ     <= stateD;
            lineAddrQ  <= lineAddrD;
            missCountQ <= missCountD;
            validQ     <= validD;
        end
    end

    // Tag and data arrays take the whole returned line in one edge.
    always_ff @(posedge CLK) begin
        if (fillWe && !RESET) begin
            tagQ[fillIndex] <= fillTag;
            for (int w = 0; w < 8; w++) begin
                dataQ[fillIndex][w] <= block_read_fIM[32*w +: 32];
            end
        end
    end

    // The second word is only available when it lives in the same line.
    always_comb begin
        hit2 = hit && (fetchWord != 3'd7);
    end

    assign Instr_valid_2IF   = hit;
    assign Instr2_valid_2IF  = hit2;
    assign Instr1_2IF        = hit  ? dataQ[fetchIndex][fetchWord] : 32'd0;
    assign Instr2_2IF        = hit2 ? dataQ[fetchIndex][nextWord]  : 32'd0;
    assign Instr_address_2IM = imAddr;
    assign iBlkRead          = blkReadReq;
    assign Miss_count        = missCountQ;

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//
// Self-checking bench for icache_direct. Instruction memory is modelled as a
// pure function of the word address, so any word the cache returns on a hit
// must equal that function. The reference keeps, per line index, whether a
// line is resident and which line address it holds, plus whether a fill is
// outstanding and for which line.
// ---------------------------------------------------------------------------
module tb_icache_direct;

    localparam int INDEX_BITS = 5;
    localparam int LINES      = 1 << INDEX_BITS;

    logic         clock;
    logic         reset;
    logic [31:0]  fetchAddr;
    logic         flush;
    logic [31:0]  instr1;
    logic [31:0]  instr2;
    logic         instrValid;
    logic         instr2Valid;
    logic [31:0]  imAddr;
    logic         blkRead;
    logic [255:0] blkData;
    logic         blkValid;
    logic [31:0]  missCount;

    icache_direct #(.INDEX_BITS(INDEX_BITS)) dut (
        .CLK                  (clock),
        .RESET                (reset),
        .Instr_address_fIF    (fetchAddr),
        .Flush                (flush),
        .Instr1_2IF           (instr1),
        .Instr2_2IF           (instr2),
        .Instr_valid_2IF      (instrValid),
        .Instr2_valid_2IF     (instr2Valid),
        .Instr_address_2IM    (imAddr),
        .iBlkRead             (blkRead),
        .block_read_fIM       (blkData),
        .block_read_fIM_valid (blkValid),
        .Miss_count           (missCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state
    bit          checksOn = 1'b0;
    bit          mResident [LINES];
    logic [26:0] mLineOf   [LINES];
    bit          mFilling  = 1'b0;
    logic [26:0] mFillLine = '0;
    logic [31:0] mMisses   = '0;

    // Instruction memory contents as a function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return (wa * 32'h9E3779B1) ^ 32'hC3A55A3C ^ (wa >> 7);
    endfunction

    function automatic logic [255:0] memLine(input logic [26:0] line);
        logic [255:0] r;
        logic [2:0]   wb;
        r = '0;
        for (int w = 0; w < 8; w++) begin
            wb = w[2:0];
            r[32*w +: 32] = memWord({line, wb, 2'b00});
        end
        return r;
    endfunction

    function automatic int idxOf(input logic [26:0] line);
        return int'(line[INDEX_BITS-1:0]);
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        logic [26:0] line;
        line = a[31:5];
        return !mFilling && !flush && mResident[idxOf(line)] && (mLineOf[idxOf(line)] == line);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs; the returned line is what memory holds for
    // the line the reference believes is being fetched.
    task automatic applyStimulus(input logic [31:0] a, input logic fl, input logic bv, input logic rst);
        fetchAddr = a;
        flush     = fl;
        blkValid  = bv;
        reset     = rst;
        blkData   = bv ? memLine(mFillLine) : {8{$urandom()}};
    endtask

    task automatic checkOutput();
        bit          h;
        bit          h2;
        logic [31:0] wordAddr;
        h        = modelHit(fetchAddr);
        h2       = h && (fetchAddr[4:2] != 3'd7);
        wordAddr = {fetchAddr[31:2], 2'b00};
        checkVal("instrValid",  {31'd0, instrValid},  {31'd0, h});
        checkVal("instr2Valid", {31'd0, instr2Valid}, {31'd0, h2});
        checkVal("instr1",      instr1, h  ? memWord(wordAddr) : 32'd0);
        checkVal("instr2",      instr2, h2 ? memWord(wordAddr + 32'd4) : 32'd0);
        checkVal("imAddr",      imAddr, mFilling ? {mFillLine, 5'b0} : {fetchAddr[31:5], 5'b0});
        checkVal("blkRead",     {31'd0, blkRead}, {31'd0, mFilling});
        checkVal("missCount",   missCount, mMisses);
    endtask

    task automatic modelUpdate();
        bit hitNow;
        hitNow = modelHit(fetchAddr);
        if (reset) begin
            for (int i = 0; i < LINES; i++) mResident[i] = 1'b0;
            mFilling = 1'b0;
            mMisses  = '0;
            checksOn = 1'b1;
        end else if (flush) begin
            for (int i = 0; i < LINES; i++) mResident[i] = 1'b0;
            mFilling = 1'b0;
        end else if (mFilling) begin
            if (blkValid) begin
                mResident[idxOf(mFillLine)] = 1'b1;
                mLineOf[idxOf(mFillLine)]   = mFillLine;
                mFilling = 1'b0;
            end
        end else if (!hitNow) begin
            mFilling  = 1'b1;
            mFillLine = fetchAddr[31:5];
            mMisses   = mMisses + 32'd1;
        end
    endtask

    task automatic runCycle(input logic [31:0] a, input logic fl, input logic bv, input logic rst);
        applyStimulus(a, fl, bv, rst);
        #3;
        if (checksOn) checkOutput();
        @(posedge clock);
        modelUpdate();
        #1;
    endtask

    int          waitLeft;
    bit          wasFilling;
    bit          bvRand;
    logic [21:0] tagPick;
    logic [31:0] randAddr;
    logic [21:0] tagOpts [3];

    initial begin
        for (int i = 0; i < LINES; i++) begin
            mResident[i] = 1'b0;
            mLineOf[i]   = '0;
        end
        tagOpts[0] = 22'h001000;
        tagOpts[1] = 22'h001001;
        tagOpts[2] = 22'h2ABCD5;
        fetchAddr = '0;
        flush     = 1'b0;
        blkValid  = 1'b0;
        reset     = 1'b1;
        blkData   = '0;
        @(posedge clock);
        #1;

        // Reset, then one checked reset cycle
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b1);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b1);

        // Cold miss with memory latency 3, then hit
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b1, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        #1;
        checkVal("coldMissCount", missCount, 32'd1);

        // Sequential fetch across the resident line
        for (int w = 0; w < 8; w++) begin
            runCycle(32'h00400000 + 32'(4 * w), 1'b0, 1'b0, 1'b0);
        end

        // Conflict eviction on index 0
        runCycle(32'h00400400, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400400, 1'b0, 1'b1, 1'b0);
        runCycle(32'h00400404, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b1, 1'b0);
        runCycle(32'h00400008, 1'b0, 1'b0, 1'b0);
        #1;
        checkVal("conflictMissCount", missCount, 32'd3);

        // Flush with the line resident, then the same address misses
        runCycle(32'h00400000, 1'b1, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b1, 1'b0);
        runCycle(32'h00400000, 1'b0, 1'b0, 1'b0);

        // Flush coincident with returned data: nothing written
        runCycle(32'h00400020, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400020, 1'b1, 1'b1, 1'b0);
        runCycle(32'h00400020, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400020, 1'b0, 1'b1, 1'b0);
        runCycle(32'h00400024, 1'b0, 1'b0, 1'b0);

        // Spurious returned data while idle is ignored
        runCycle(32'h00400024, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a fill
        runCycle(32'h00400040, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400040, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400040, 1'b0, 1'b0, 1'b1);
        #1;
        checkVal("blkReadAfterReset", {31'd0, blkRead}, 32'd0);
        checkVal("missCountAfterReset", missCount, 32'd0);
        runCycle(32'h00400020, 1'b0, 1'b0, 1'b0);
        runCycle(32'h00400020, 1'b0, 1'b1, 1'b0);

        // Randomised traffic over a few tags and indices
        waitLeft = 0;
        for (int n = 0; n < 600; n++) begin
            tagPick  = tagOpts[$urandom_range(0, 2)];
            randAddr = {tagPick, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if (mFilling) begin
                bvRand = (waitLeft == 0);
                if (waitLeft > 0) waitLeft--;
            end else begin
                bvRand = ($urandom_range(0, 9) == 0);
            end
            wasFilling = mFilling;
            runCycle(randAddr, ($urandom_range(0, 39) == 0), bvRand, ($urandom_range(0, 149) == 0));
            if (mFilling && !wasFilling) waitLeft = $urandom_range(0, 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the IF stage and instruction memory. IF presents a fetch address each cycle; hits return the instruction word (and the following word, for superscalar fetch) combinationally in the same cycle. Misses run a single-outstanding 256-bit block fill over the IM block interface, driving `iBlkRead` and replacing the unused pass-through path. IF stalls while `Instr_valid_2IF` is low.

## Interface
Parameters:
- INDEX_BITS, 5, line index width; 2^INDEX_BITS lines of 32 bytes (default 1 KiB)

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- Instr_address_fIF  in  32  byte fetch address from IF; bits [1:0] ignored
- Flush  in  1  invalidate all lines (syscall); synchronous
- Instr1_2IF  out  32  word at fetch address; 0 when Instr_valid_2IF=0
- Instr2_2IF  out  32  word at fetch address+4; 0 when Instr2_valid_2IF=0
- Instr_valid_2IF  out  1  Instr1_2IF valid (hit, IDLE state, no Flush)
- Instr2_valid_2IF  out  1  Instr2_2IF valid (Instr_valid_2IF=1 and word index < 7)
- Instr_address_2IM  out  32  line-aligned block address to IM (bits [4:0]=0)
- iBlkRead  out  1  block read request
- block_read_fIM  in  256  returned line; word w at bits [32w+31:32w]
- block_read_fIM_valid  in  1  returned line valid this cycle
- Miss_count  out  32  number of fills started since reset; wraps at 2^32

## Operation
- Address split: word = addr[4:2], index = addr[4+INDEX_BITS:5], tag = addr[31:5+INDEX_BITS].
- Storage per line: valid bit, tag, 8 data words. Reads are combinational; writes occur on the clock edge.
- State machine with two states:
  - IDLE: hit = valid[index] && tag match. On hit, assert Instr_valid_2IF. On miss (and no Flush), latch the line address, increment Miss_count, and go to FILL.
  - FILL: iBlkRead=1. Instr_address_2IM = latched line address. Instr_valid_2IF=0. Instr_address_fIF is ignored. When block_read_fIM_valid=1, write data, tag, and valid=1 to the latched index, then go to IDLE.
- Instr_address_2IM in IDLE = {Instr_address_fIF[31:5], 5'b0}.
- Flush: at the edge, clear all valid bits. If in FILL, abort the fill (no write) and return to IDLE. Flush beats a same-cycle block_read_fIM_valid. Instr_valid_2IF=0 during the Flush cycle. Miss_count is unaffected.
- block_read_fIM_valid while in IDLE is ignored.
- RESET: state IDLE, all valid bits 0, Miss_count 0. RESET mid-FILL abandons the fill. Tag and data storage need not be reset.

## Timing
- Reset outputs: iBlkRead=0, Instr_valid_2IF=0 (all lines invalid), Instr2_valid_2IF=0, Instr1_2IF=0, Instr2_2IF=0, Miss_count=0, Instr_address_2IM = aligned fetch address.
- Hit latency: 0 cycles (combinational, same cycle).
- Miss sequence:
  - Cycle t: miss seen in IDLE.
  - Cycle t+1: FILL begins, iBlkRead=1.
  - Cycle t+1+k: block_read_fIM_valid, where k≥0 is memory latency; line written at the end of this cycle.
  - Cycle t+2+k: IDLE, hit for the same address.
  - Minimum miss penalty: 2 cycles.
- iBlkRead stays high continuously from FILL entry until the valid cycle, inclusive, then drops in the next cycle.
- Only one fill is outstanding; no request pipelining.
- Address change during FILL: the fill completes for the latched line, then the new address is looked up in IDLE (and may miss again).

## Test plan
- Cold miss: after RESET, fetch 0x00400000 with memory returning after 3 cycles.
  - iBlkRead high for 4 cycles, Instr_address_2IM=0x00400000.
  - Next cycle: hit, Instr1 = word 0, Instr2 = word 1, Miss_count=1.
- Sequential fetch 0x00400000..0x0040001C after fill: all hit, no iBlkRead. At 0x0040001C, Instr2_valid_2IF=0.
- Conflict eviction (INDEX_BITS=5): fill 0x00400000, then fetch 0x00400400 (same index, new tag) → miss and refill. Re-fetch 0x00400000 → miss again, Miss_count=3.
- Flush: with line resident, pulse Flush → Instr_valid_2IF=0 in that cycle. Next cycle, the same address misses.
- Flush during FILL, coincident with block_read_fIM_valid → no line written, state IDLE, the following lookup misses.
- RESET asserted mid-FILL → iBlkRead=0 next cycle, Miss_count=0, all lines invalid.
